// File: rtl/regfile_mp_if.sv
// Purpose : bundles the register-file access signals (write port, read ports, clear control/status).
// Latency : n/a (signal container only).
// Backpressure: none; writes issued while a clear runs are dropped and flagged on wr_drop.
// Ports   : master = decode/writeback side (drives addresses, data, clr_req);
//           slave  = register file (drives rdata, clr_busy, clr_done, wr_drop).
interface regfile_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic                  we;
    logic [AW-1:0]         waddr;
    logic [XLEN-1:0]       wdata;
    logic [NRD*AW-1:0]     raddr;
    logic [NRD*XLEN-1:0]   rdata;
    logic                  clr_req;
    logic                  clr_busy;
    logic                  clr_done;
    logic                  wr_drop;

    modport master (
        output we, waddr, wdata, raddr, clr_req,
        input  rdata, clr_busy, clr_done, wr_drop
    );

    modport slave (
        input  we, waddr, wdata, raddr, clr_req,
        output rdata, clr_busy, clr_done, wr_drop
    );
endinterface

// File: rtl/regfile_mp.sv
// Purpose : NRD-read / 1-write integer register file with hard-wired x0 and a bulk-clear sequencer.
// Latency : reads combinational (0 cycles); writes visible the cycle after; clear takes NREGS-1 cycles + 1 done cycle.
// Backpressure: none; writes arriving while the clear sequencer is active are discarded and flagged on wr_drop.
// Ports   : clk, rst_n (async active-low) plain; bus (regfile_mp_if.slave) carries we/waddr/wdata,
//           raddr/rdata (port k at slice k), clr_req in, clr_busy/clr_done/wr_drop out (all registered).
// Config  : REGFILE_BYPASS_EN defined -> an accepted write is forwarded to matching read ports in the same cycle.
module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_mp_if.slave   bus
);
    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] PTR_FIRST = AW'(1);
    localparam logic [AW-1:0] PTR_LAST  = AW'(NREGS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_q;
    logic [AW-1:0]       ptr_q;
    logic                clr_busy_q;
    logic                clr_done_q;
    logic                wr_drop_q;
    logic [XLEN-1:0]     regs_q [NREGS];

    logic                wr_nz;
    logic                wr_ok;
    logic [NRD*XLEN-1:0] rdata_w;

    // x0 writes are neither performed nor reported as drops.
    assign wr_nz = bus.we && (bus.waddr != '0);
    assign wr_ok = wr_nz && (state_q == ST_IDLE);

    // ------------------------------------------------------------------
    // Clear sequencer. Status outputs are registered alongside the state so
    // clr_busy tracks CLEAR and clr_done tracks DONE without decode glitches.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
            wr_drop_q  <= 1'b0;
        end else begin
            wr_drop_q  <= wr_nz && (state_q != ST_IDLE);
            clr_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.clr_req) begin
                        state_q    <= ST_CLEAR;
                        ptr_q      <= PTR_FIRST;
                        clr_busy_q <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    // Hold ptr on the last register so it never wraps.
                    if (ptr_q == PTR_LAST) begin
                        state_q    <= ST_DONE;
                        clr_busy_q <= 1'b0;
                        clr_done_q <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + PTR_FIRST;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    clr_busy_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Storage. Writes only land in IDLE and clearing only happens in CLEAR,
    // so the two update sources are mutually exclusive. Entry 0 is never
    // written and stays zero from reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_ok) begin
            regs_q[bus.waddr] <= bus.wdata;
        end else if (state_q == ST_CLEAR) begin
            regs_q[ptr_q] <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Read ports: independent combinational muxes.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;

        assign ra = bus.raddr[k*AW +: AW];

        always_comb begin
            rd = regs_q[ra];
`ifdef REGFILE_BYPASS_EN
            // Forward only writes that will actually be committed this edge.
            if (wr_ok && (bus.waddr == ra)) begin
                rd = bus.wdata;
            end
`endif
            if (ra == '0) begin
                rd = '0;
            end
        end

        assign rdata_w[k*XLEN +: XLEN] = rd;
    end

    assign bus.rdata    = rdata_w;
    assign bus.clr_busy = clr_busy_q;
    assign bus.clr_done = clr_done_q;
    assign bus.wr_drop  = wr_drop_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Purpose : self-checking bench for regfile_mp (reset, read/write, x0, bypass, clear, drop, reset mid-clear).
// Latency : expects 0-cycle reads, 1-cycle write visibility, registered status outputs.
// Backpressure: drives writes during clear and expects them to be dropped with a wr_drop pulse.
module tb_regfile_mp;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic clk;
    logic rst_n;

    regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) rf_if ();

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (rf_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int              vectors     = 0;
    int              miscompares = 0;
    logic [31:0]     mdl [NREGS];
    logic [31:0]     exp_q [$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Drive both read addresses, push expectations, pop/compare once settled.
    task automatic read_pair(input string tag, input int a0, input int a1,
                             input logic [31:0] e0, input logic [31:0] e1);
        rf_if.raddr = {AW'(a1), AW'(a0)};
        exp_q.push_back(e0);
        exp_q.push_back(e1);
        #1;
        check_val({tag, "_p0"}, rf_if.rdata[31:0],  exp_q.pop_front());
        check_val({tag, "_p1"}, rf_if.rdata[63:32], exp_q.pop_front());
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < NREGS; a++) begin
            @(negedge clk);
            read_pair(tag, a, NREGS - 1 - a, mdl[a], mdl[NREGS - 1 - a]);
        end
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        @(negedge clk);
        rf_if.we    = 1'b1;
        rf_if.waddr = AW'(a);
        rf_if.wdata = d;
        @(negedge clk);
        rf_if.we    = 1'b0;
        if (a != 0) mdl[a] = d;
    endtask

    task automatic fill_all(input logic [31:0] salt);
        for (int a = 1; a < NREGS; a++) begin
            wr(a, (32'(a) * 32'h0101_0101) ^ salt);
        end
    endtask

    task automatic zero_model();
        for (int a = 0; a < NREGS; a++) mdl[a] = '0;
    endtask

    // Samples from the current negedge onward; counts busy cycles until clr_done.
    task automatic wait_done(output int nbusy);
        bit seen;
        nbusy = 0;
        seen  = 1'b0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (rf_if.clr_done) begin
                seen = 1'b1;
                check_val("busy_in_done", 32'(rf_if.clr_busy), 32'd0);
                break;
            end
            if (rf_if.clr_busy) nbusy++;
            @(negedge clk);
        end
        if (!seen) check_val("clr_done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          nb;
        int          n;
        logic [31:0] e_byp;

        rst_n         = 1'b0;
        rf_if.we      = 1'b0;
        rf_if.waddr   = '0;
        rf_if.wdata   = '0;
        rf_if.raddr   = '0;
        rf_if.clr_req = 1'b0;
        zero_model();

        // 1: reset
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_busy", 32'(rf_if.clr_busy), 32'd0);
        check_val("rst_done", 32'(rf_if.clr_done), 32'd0);
        check_val("rst_drop", 32'(rf_if.wr_drop),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        read_all("rst_rd");

        // 2: write/read, x0 writes ignored and never forwarded
        wr(5, 32'hDEAD_BEEF);
        read_pair("wr5", 5, 5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        @(negedge clk);
        rf_if.we    = 1'b1;
        rf_if.waddr = '0;
        rf_if.wdata = 32'h1234;
        read_pair("x0_same", 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        rf_if.we = 1'b0;
        read_pair("x0_after", 0, 5, 32'h0, 32'hDEAD_BEEF);
        check_val("x0_nodrop", 32'(rf_if.wr_drop), 32'd0);

        // 3: same-cycle read of a write
        wr(7, 32'h11);
`ifdef REGFILE_BYPASS_EN
        e_byp = 32'h22;
`else
        e_byp = 32'h11;
`endif
        rf_if.we    = 1'b1;
        rf_if.waddr = AW'(7);
        rf_if.wdata = 32'h22;
        read_pair("byp_same", 7, 7, e_byp, e_byp);
        @(negedge clk);
        rf_if.we = 1'b0;
        mdl[7]   = 32'h22;
        read_pair("byp_next", 7, 5, 32'h22, 32'hDEAD_BEEF);

        // 4: full clear
        fill_all(32'h5A00_0001);
        read_all("fill_rd");
        @(negedge clk);
        rf_if.clr_req = 1'b1;
        @(negedge clk);
        rf_if.clr_req = 1'b0;
        wait_done(nb);
        check_val("clr_busy_cycles", 32'(nb), 32'd31);
        @(negedge clk);
        #1;
        check_val("clr_done_width", 32'(rf_if.clr_done), 32'd0);
        check_val("clr_idle_busy",  32'(rf_if.clr_busy), 32'd0);
        zero_model();
        read_all("clr_rd");

        // 5: same-edge write+clear, write during clear, clr_req during busy
        @(negedge clk);
        rf_if.clr_req = 1'b1;
        rf_if.we      = 1'b1;
        rf_if.waddr   = AW'(3);
        rf_if.wdata   = 32'hAAAA;
        mdl[3]        = 32'hAAAA;
        @(negedge clk);
        rf_if.wdata   = 32'h5555;
        read_pair("clr_old_x3", 3, 3, 32'hAAAA, 32'hAAAA);
        check_val("drop_first", 32'(rf_if.wr_drop),  32'd0);
        check_val("busy_first", 32'(rf_if.clr_busy), 32'd1);
        @(negedge clk);
        #1;
        check_val("drop_pulse", 32'(rf_if.wr_drop), 32'd1);
        rf_if.we      = 1'b0;
        rf_if.clr_req = 1'b0;
        @(negedge clk);
        #1;
        check_val("drop_end", 32'(rf_if.wr_drop), 32'd0);
        @(negedge clk);
        wait_done(nb);
        check_val("clr2_busy_rest", 32'(nb), 32'd28);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check_val("no_requeue", 32'(rf_if.clr_busy | rf_if.clr_done), 32'd0);
        end
        zero_model();
        @(negedge clk);
        read_pair("x3_after_clr", 3, 7, 32'h0, 32'h0);

        // clr_req held high re-triggers after DONE
        @(negedge clk);
        rf_if.clr_req = 1'b1;
        @(negedge clk);
        wait_done(nb);
        check_val("hold_busy1", 32'(nb), 32'd31);
        @(negedge clk);
        #1;
        check_val("hold_idle", 32'(rf_if.clr_busy), 32'd0);
        @(negedge clk);
        #1;
        check_val("hold_retrig", 32'(rf_if.clr_busy), 32'd1);
        rf_if.clr_req = 1'b0;
        wait_done(nb);
        check_val("hold_busy2", 32'(nb), 32'd31);

        // 6: reset mid-clear
        fill_all(32'h0F0F_0003);
        @(negedge clk);
        rf_if.clr_req = 1'b1;
        @(negedge clk);
        rf_if.clr_req = 1'b0;
        n = 0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (rf_if.clr_busy) n++;
            if (n == 10) break;
            @(negedge clk);
        end
        check_val("mid_busy_count", 32'(n), 32'd10);
        read_pair("mid_rd", 9, 10, 32'h0, mdl[10]);
        rst_n = 1'b0;
        #1;
        check_val("abort_busy", 32'(rf_if.clr_busy), 32'd0);
        check_val("abort_done", 32'(rf_if.clr_done), 32'd0);
        zero_model();
        read_pair("abort_rd", 10, 31, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            check_val("abort_nodone", 32'(rf_if.clr_done | rf_if.clr_busy), 32'd0);
        end
        read_all("abort_all");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
